reg_space_master: RTL and testbench
===================================

Name: reg_space_master

Overview:
- Initiator side of the register-space request interface. It accepts one register command at a time on a simple command port and drives the wreq_* / rreq_* request channels toward a register-space block.
- For reads, it collects the result from the rack_* channel. Every command, read or write, returns exactly one response with data and an error flag.
- It sits between a bus bridge or debug controller and the generated register-space slaves.
- An optional watchdog ends accesses that the target never acknowledges, such as reads into spaces with no read path (rreq_rdy tied 0).

Parameters:
- ADDR_W, 16, width of the register address.
- DATA_W, 32, width of the register data.
- TIMEOUT, 255, maximum number of cycles a request valid (or rack_rdy) is held before the access is abandoned; must be >= 1; used only with the optional feature.
- ERR_DATA, 0, value returned on rsp_data for any errored access.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- cmd_vld  in  1  command valid.
- cmd_rdy  out  1  command ready.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  command address.
- cmd_wdata  in  DATA_W  write data.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response ready.
- rsp_data  out  DATA_W  read data; 0 for writes; ERR_DATA on error.
- rsp_err  out  1  access timed out.
- wreq_addr  out  ADDR_W  write request address.
- wreq_data  out  DATA_W  write request data.
- wreq_vld  out  1  write request valid.
- wreq_rdy  in  1  write request ready.
- rreq_addr  out  ADDR_W  read request address.
- rreq_vld  out  1  read request valid.
- rreq_rdy  in  1  read request ready.
- rack_data  in  DATA_W  read acknowledge data.
- rack_vld  in  1  read acknowledge valid.
- rack_rdy  out  1  read acknowledge ready.

Behaviour:
- Clocking and reset: single clock domain, clk. rst_n is asynchronous and active-low.
- Reset state: FSM goes to IDLE. All outputs reset to 0: cmd_rdy, rsp_vld, rsp_err, rsp_data, wreq_vld, rreq_vld, rack_rdy, and the address/data registers.
- Reset mid-operation abandons the access; no response is produced.
- Handshake rule: a transfer occurs in a cycle where vld && rdy. Exactly one access is outstanding at a time.
- FSM states: IDLE, WREQ, RREQ, RACK, RSP. Only the listed outputs are asserted in each state.
- IDLE:
  - cmd_rdy = 1.
  - On cmd_vld && cmd_rdy, latch cmd_addr and cmd_wdata into the request registers.
  - Next state is WREQ if cmd_wr = 1, otherwise RREQ.
- WREQ:
  - wreq_vld = 1; wreq_addr and wreq_data are held stable.
  - On wreq_rdy: go to RSP with rsp_data = 0 and rsp_err = 0.
- RREQ:
  - rreq_vld = 1; rreq_addr is held stable.
  - On rreq_rdy: go to RACK.
- RACK:
  - rack_rdy = 1.
  - On rack_vld: capture rack_data into rsp_data, set rsp_err = 0, go to RSP.
  - rack_vld or rack_data arriving outside RACK is ignored. The target must hold rack_vld until it sees rack_rdy.
- RSP:
  - rsp_vld = 1; rsp_data and rsp_err are held stable.
  - On rsp_rdy: go to IDLE.
  - cmd_rdy stays 0 until IDLE is re-entered. No command is accepted in the cycle where the response handshake completes.
- Latency with zero-wait target and sink:
  - Command accepted in cycle 0.
  - Write: wreq_vld in cycle 1, rsp_vld in cycle 2.
  - Read: rreq_vld in cycle 1, rack_rdy in cycle 2, rsp_vld in cycle 3.
- Sustained throughput: one write per 3 cycles, one read per 4 cycles.
- Request addresses: wreq_addr and rreq_addr are driven from the same latched address register. They are meaningful only while their channel's valid is asserted.
- Without the optional feature, the FSM waits in WREQ, RREQ and RACK indefinitely.

Optional Feature:
- Macro name: REG_SPACE_MASTER_TIMEOUT_EN.
- Counter width: $clog2(TIMEOUT+1) bits.
- Counter operation:
  - Cleared on entry to WREQ, RREQ and RACK.
  - Increments in each cycle of those states in which the state's handshake does not occur.
- Timeout condition: counter == TIMEOUT-1 and no handshake this cycle. Result: the valid (or rack_rdy) is held exactly TIMEOUT cycles, then the FSM goes to RSP with rsp_err = 1 and rsp_data = ERR_DATA.
- Timeout in RREQ skips RACK. Dropping the valid without a handshake is intentional.
- If the handshake occurs in the timeout cycle, the handshake wins and there is no error.
- Macro undefined: no counter is built, rsp_err is tied to 0, and ERR_DATA is unused.

Test Plan:
- Write, zero-wait: cmd wr addr=0x0020 data=0x00000A5D, wreq_rdy=1 -> wreq_vld high in cycle 1 only, with wreq_addr=0x0020 and wreq_data=0x00000A5D; rsp_vld in cycle 2 with rsp_data=0 and rsp_err=0.
- Read, stalled target: rreq_rdy asserted 3 cycles late, rack_vld 2 cycles after that with data 0x00000F5C -> rreq_vld held 4 cycles; rsp_data=0x00000F5C, rsp_err=0.
- Timeout, TIMEOUT=8 with macro defined, rreq_rdy tied 0 -> rreq_vld high exactly 8 cycles, then rsp_vld with rsp_err=1 and rsp_data=ERR_DATA; rack_rdy never asserted.
- Boundary, same TIMEOUT=8 setup -> wreq_rdy asserted in cycle 8 of WREQ gives rsp_err=0; wreq_rdy never asserted gives rsp_err=1.
- Backpressure: rsp_rdy held 0 for 5 cycles -> rsp_vld, rsp_data and rsp_err stable, cmd_rdy=0 throughout; IDLE reached the cycle after rsp_rdy=1.
- Reset mid-RACK: rst_n pulsed low -> all outputs 0 immediately (asynchronous); no response issued; a new command is accepted normally afterwards.

Source files
------------

// File: rtl/reg_space_master_if.sv
// rtl/reg_space_master_if.sv - command/response and register request channels of reg_space_master
//
// Purpose: bundles the command port, response port and the wreq/rreq/rack
// register-space channels driven by reg_space_master.
// Modports:
//   master - the reg_space_master view (drives cmd_rdy, rsp_*, wreq_*, rreq_*, rack_rdy)
//   slave  - the environment view (bridge + register-space target)
interface reg_space_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  // command port
  logic              cmd_vld;
  logic              cmd_rdy;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  // response port
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  // write request channel
  logic [ADDR_W-1:0] wreq_addr;
  logic [DATA_W-1:0] wreq_data;
  logic              wreq_vld;
  logic              wreq_rdy;
  // read request channel
  logic [ADDR_W-1:0] rreq_addr;
  logic              rreq_vld;
  logic              rreq_rdy;
  // read acknowledge channel
  logic [DATA_W-1:0] rack_data;
  logic              rack_vld;
  logic              rack_rdy;

  modport master (
    input  cmd_vld, cmd_wr, cmd_addr, cmd_wdata,
    output cmd_rdy,
    output rsp_vld, rsp_data, rsp_err,
    input  rsp_rdy,
    output wreq_addr, wreq_data, wreq_vld,
    input  wreq_rdy,
    output rreq_addr, rreq_vld,
    input  rreq_rdy,
    input  rack_data, rack_vld,
    output rack_rdy
  );

  modport slave (
    output cmd_vld, cmd_wr, cmd_addr, cmd_wdata,
    input  cmd_rdy,
    input  rsp_vld, rsp_data, rsp_err,
    output rsp_rdy,
    input  wreq_addr, wreq_data, wreq_vld,
    output wreq_rdy,
    input  rreq_addr, rreq_vld,
    output rreq_rdy,
    output rack_data, rack_vld,
    input  rack_rdy
  );
endinterface

// File: rtl/reg_space_master.sv
// rtl/reg_space_master.sv - initiator for the register-space wreq/rreq/rack request interface
//
// Purpose: accepts one register command at a time and turns it into a write
// request (wreq_*) or a read request (rreq_*) followed by a read acknowledge
// (rack_*). Every command produces exactly one response (rsp_data, rsp_err).
//
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset; abandons any access in flight
//   bus    - reg_space_master_if.master: cmd_*, rsp_*, wreq_*, rreq_*, rack_*
//
// Optional feature: define REG_SPACE_MASTER_TIMEOUT_EN to build a watchdog
// that abandons a request (or acknowledge wait) after TIMEOUT cycles and
// answers with rsp_err=1, rsp_data=ERR_DATA. Without it rsp_err is tied 0.
module reg_space_master #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  reg_space_master_if.master  bus
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("reg_space_master: TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WREQ = 3'd1,
    RREQ = 3'd2,
    RACK = 3'd3,
    RSP  = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;

  // All outputs are flops decoded from the next state, so every output is 0
  // while rst_n is low and cmd_rdy only rises one cycle after reset release.
  logic              cmd_rdy_q;
  logic              wreq_vld_q;
  logic              rreq_vld_q;
  logic              rack_rdy_q;
  logic              rsp_vld_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [DATA_W-1:0] rsp_data_d;

  logic              cmd_take;
  logic              hs;
  logic              waiting;

`ifdef REG_SPACE_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              rsp_err_q;
  logic              rsp_err_d;
`endif

  assign waiting = (state_q == WREQ) || (state_q == RREQ) || (state_q == RACK);

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    cmd_take   = 1'b0;
    hs         = 1'b0;
`ifdef REG_SPACE_MASTER_TIMEOUT_EN
    rsp_err_d  = rsp_err_q;
    cnt_d      = '0;
`endif

    unique case (state_q)
      IDLE: begin
        cmd_take = bus.cmd_vld && cmd_rdy_q;
        if (cmd_take) begin
          state_d = bus.cmd_wr ? WREQ : RREQ;
        end
      end
      WREQ: begin
        hs = bus.wreq_rdy;
        if (hs) begin
          state_d    = RSP;
          rsp_data_d = '0;
`ifdef REG_SPACE_MASTER_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
        end
      end
      RREQ: begin
        hs = bus.rreq_rdy;
        if (hs) begin
          state_d = RACK;
        end
      end
      RACK: begin
        hs = bus.rack_vld;
        if (hs) begin
          state_d    = RSP;
          rsp_data_d = bus.rack_data;
`ifdef REG_SPACE_MASTER_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
        end
      end
      RSP: begin
        if (bus.rsp_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef REG_SPACE_MASTER_TIMEOUT_EN
    // The counter only advances while a wait state is held without its
    // handshake; any state change (entry, handshake, expiry) leaves it at 0.
    // A handshake in the final cycle never reaches this branch, so it wins.
    if (waiting && !hs) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        // Expiry in RREQ deliberately skips RACK and drops rreq_vld.
        state_d    = RSP;
        rsp_data_d = ERR_DATA;
        rsp_err_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_rdy_q  <= 1'b0;
      wreq_vld_q <= 1'b0;
      rreq_vld_q <= 1'b0;
      rack_rdy_q <= 1'b0;
      rsp_vld_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_rdy_q  <= (state_d == IDLE);
      wreq_vld_q <= (state_d == WREQ);
      rreq_vld_q <= (state_d == RREQ);
      rack_rdy_q <= (state_d == RACK);
      rsp_vld_q  <= (state_d == RSP);
      rsp_data_q <= rsp_data_d;
      if (cmd_take) begin
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
      end
    end
  end

`ifdef REG_SPACE_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.rsp_vld   = rsp_vld_q;
  assign bus.rsp_data  = rsp_data_q;
  // Both request channels share one latched address register.
  assign bus.wreq_addr = addr_q;
  assign bus.wreq_data = wdata_q;
  assign bus.wreq_vld  = wreq_vld_q;
  assign bus.rreq_addr = addr_q;
  assign bus.rreq_vld  = rreq_vld_q;
  assign bus.rack_rdy  = rack_rdy_q;

endmodule

// File: tb/tb_reg_space_master.sv
// tb/tb_reg_space_master.sv - scoreboard testbench for reg_space_master
module tb_reg_space_master;

  localparam int          AW    = 16;
  localparam int          DW    = 32;
  localparam int          TO    = 8;
  localparam logic [31:0] ERR_D = 32'hDEAD_BEEF;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  // expected response: {data, err}
  logic [32:0] sb[$];

  reg_space_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  reg_space_master #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO),
    .ERR_DATA(ERR_D)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && bus.rsp_vld && bus.rsp_rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rsp_data", bus.rsp_data, e[32:1]);
        check("rsp_err", bus.rsp_err, e[0]);
      end
    end
  end

  task automatic wait_cmd_rdy();
    int n;
    n = 0;
    while (!bus.cmd_rdy && n < 20) begin
      tick();
      n++;
    end
    check("cmd_rdy_wait", bus.cmd_rdy, 1);
  endtask

  task automatic issue(input bit wr, input logic [15:0] a, input logic [31:0] wd);
    wait_cmd_rdy();
    bus.cmd_vld   = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    tick();
    bus.cmd_vld   = 1'b0;
    bus.cmd_wdata = 32'h5555_5555;
    bus.cmd_addr  = 16'hFFFF;
  endtask

  // One access against a target that waits req_wait / ack_wait cycles.
  task automatic do_access(input bit wr, input logic [15:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int req_wait, input int ack_wait);
    bus.rsp_rdy = 1'b1;
    issue(wr, a, wd);
    sb.push_back({wr ? 32'h0 : rd, 1'b0});
    for (int i = 0; i <= req_wait; i++) begin
      if (wr) begin
        check("wreq_vld", bus.wreq_vld, 1);
        check("wreq_addr", bus.wreq_addr, a);
        check("wreq_data", bus.wreq_data, wd);
        if (i == req_wait) bus.wreq_rdy = 1'b1;
      end else begin
        check("rreq_vld", bus.rreq_vld, 1);
        check("rreq_addr", bus.rreq_addr, a);
        if (i == req_wait) bus.rreq_rdy = 1'b1;
      end
      tick();
    end
    bus.wreq_rdy = 1'b0;
    bus.rreq_rdy = 1'b0;
    if (!wr) begin
      for (int i = 0; i <= ack_wait; i++) begin
        check("rack_rdy", bus.rack_rdy, 1);
        check("rreq_vld_low", bus.rreq_vld, 0);
        if (i == ack_wait) begin
          bus.rack_vld  = 1'b1;
          bus.rack_data = rd;
        end
        tick();
      end
      bus.rack_vld  = 1'b0;
      bus.rack_data = 32'h0BAD_0BAD;
    end
    check("wreq_vld_low", bus.wreq_vld, 0);
    check("rsp_vld", bus.rsp_vld, 1);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n         = 1'b0;
    bus.cmd_vld   = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_rdy   = 1'b1;
    bus.wreq_rdy  = 1'b0;
    bus.rreq_rdy  = 1'b0;
    bus.rack_vld  = 1'b0;
    bus.rack_data = '0;
    #3;
    check("rst_cmd_rdy", bus.cmd_rdy, 0);
    check("rst_rsp_vld", bus.rsp_vld, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_wreq_vld", bus.wreq_vld, 0);
    check("rst_rreq_vld", bus.rreq_vld, 0);
    check("rst_rack_rdy", bus.rack_rdy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // zero-wait write, then stalled read (rdy 3 late, ack 2 after that)
    do_access(1'b1, 16'h0020, 32'h0000_0A5D, 32'h0, 0, 0);
    do_access(1'b0, 16'h0044, 32'h0, 32'h0000_0F5C, 3, 2);
    // handshake in the last allowed cycle of WREQ
    do_access(1'b1, 16'h0031, 32'hCAFE_0001, 32'h0, TO - 1, 0);
    do_access(1'b0, 16'h0032, 32'h0, 32'h7777_0002, 0, TO - 1);

    // response backpressure on a zero-wait read; rack_vld outside RACK ignored
    bus.rsp_rdy   = 1'b0;
    bus.rreq_rdy  = 1'b1;
    bus.rack_vld  = 1'b1;
    bus.rack_data = 32'h1234_5678;
    issue(1'b0, 16'h0050, 32'h0);
    sb.push_back({32'h1234_5678, 1'b0});
    check("bp_rreq_vld_c1", bus.rreq_vld, 1);
    check("bp_rack_rdy_c1", bus.rack_rdy, 0);
    tick();
    check("bp_rack_rdy_c2", bus.rack_rdy, 1);
    tick();
    bus.rreq_rdy  = 1'b0;
    bus.rack_vld  = 1'b0;
    bus.rack_data = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_vld", bus.rsp_vld, 1);
      check("bp_rsp_data", bus.rsp_data, 32'h1234_5678);
      check("bp_rsp_err", bus.rsp_err, 0);
      check("bp_cmd_rdy", bus.cmd_rdy, 0);
      tick();
    end
    bus.rsp_rdy = 1'b1;
    check("bp_cmd_rdy_hs", bus.cmd_rdy, 0);
    tick();
    check("bp_idle_cmd_rdy", bus.cmd_rdy, 1);
    check("bp_idle_rsp_vld", bus.rsp_vld, 0);

`ifdef REG_SPACE_MASTER_TIMEOUT_EN
    // read into a target that never accepts
    issue(1'b0, 16'h0060, 32'h0);
    sb.push_back({ERR_D, 1'b1});
    for (int i = 0; i < TO; i++) begin
      check("to_rreq_vld", bus.rreq_vld, 1);
      check("to_rack_rdy", bus.rack_rdy, 0);
      tick();
    end
    check("to_rreq_drop", bus.rreq_vld, 0);
    check("to_rack_rdy_rsp", bus.rack_rdy, 0);
    check("to_rsp_vld", bus.rsp_vld, 1);
    tick();
    // write that is never accepted
    issue(1'b1, 16'h0061, 32'h1111_2222);
    sb.push_back({ERR_D, 1'b1});
    for (int i = 0; i < TO; i++) begin
      check("tow_wreq_vld", bus.wreq_vld, 1);
      tick();
    end
    check("tow_wreq_drop", bus.wreq_vld, 0);
    check("tow_rsp_vld", bus.rsp_vld, 1);
    tick();
`else
    // without the watchdog a stalled request is held indefinitely
    issue(1'b0, 16'h0060, 32'h0);
    sb.push_back({32'h6060_6060, 1'b0});
    for (int i = 0; i < 3 * TO; i++) begin
      check("stall_rreq_vld", bus.rreq_vld, 1);
      tick();
    end
    bus.rreq_rdy = 1'b1;
    tick();
    bus.rreq_rdy  = 1'b0;
    bus.rack_vld  = 1'b1;
    bus.rack_data = 32'h6060_6060;
    tick();
    bus.rack_vld = 1'b0;
    check("stall_rsp_vld", bus.rsp_vld, 1);
    tick();
`endif

    // reset while waiting in RACK: no response, outputs cleared at once
    issue(1'b0, 16'h0070, 32'h0);
    bus.rreq_rdy = 1'b1;
    tick();
    bus.rreq_rdy = 1'b0;
    check("rr_rack_rdy", bus.rack_rdy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rr_rack_rdy_0", bus.rack_rdy, 0);
    check("rr_cmd_rdy_0", bus.cmd_rdy, 0);
    check("rr_rsp_vld_0", bus.rsp_vld, 0);
    check("rr_rreq_addr_0", bus.rreq_addr, 0);
    check("rr_rsp_data_0", bus.rsp_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_access(1'b1, 16'h0080, 32'hABCD_EF01, 32'h0, 1, 0);

    // random traffic within the watchdog budget
    for (int k = 0; k < 10; k++) begin
      do_access(1'($urandom_range(0, 1)), 16'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1);
  end

endmodule
